// File: rtl/blink_rate_timer_pkg.sv
// Shared types and helpers for the blink rate timer.
// Rate-step codes and the period-minus-one helper.
package blink_rate_timer_pkg;

    typedef enum logic [1:0] {
        RATE_HOLD = 2'd0,
        RATE_UP   = 2'd1,
        RATE_DOWN = 2'd2
    } rate_step_e;

    // Period of rate k is 2^(min_log2+k); counter reloads with period-1.
    function automatic logic [63:0] period_m1(
        input int min_log2,
        input int k
    );
        return (64'd1 << (min_log2 + k)) - 64'd1;
    endfunction

endpackage

// File: rtl/blink_rate_timer_if.sv
// Control/beat bundle between button conditioner, timer and blinker.
// The timer side is the slave.
interface blink_rate_timer_if #(
    parameter int RATE_W = 3
);
    logic              en;
    logic              faster;
    logic              slower;
    logic              tick;
    logic [RATE_W-1:0] rate;

    modport master (
        output en,
        output faster,
        output slower,
        input  tick,
        input  rate
    );

    modport slave (
        input  en,
        input  faster,
        input  slower,
        output tick,
        output rate
    );
endinterface

// File: rtl/blink_rate_timer_reload_counter.sv
// Loadable down-counter: reloads from reload_val when it reaches zero.
// Holds while en is low.
module reload_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] reload_val,
    input  logic [W-1:0] rst_val,
    output logic [W-1:0] count,
    output logic         zero
);
    logic [W-1:0] count_d;

    assign zero = (count == '0);

    always_comb begin
        count_d = count;
        if (en) count_d = zero ? reload_val : count - W'(1);
    end

    dffr #(.W(W)) u_count (
        .clk     (clk),
        .rst     (rst),
        .rst_val (rst_val),
        .d       (count_d),
        .q       (count)
    );
endmodule

// File: rtl/dffr.sv
// Resettable D flip-flop bank with a synchronous, active-high reset.
// The reset value is a port so it can be a derived constant.
module dffr #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= rst_val;
        else     q <= d;
    end
endmodule

// File: rtl/blink_rate_timer.sv
// Programmable power-of-two beat generator feeding the blinker.
// Owns the rate index; the period counter lives in reload_counter.
module blink_rate_timer
    import blink_rate_timer_pkg::*;
#(
    parameter int MIN_LOG2   = 20,
    parameter int NUM_RATES  = 6,
    parameter int RESET_RATE = 3,
    parameter int RATE_W     = 3,
    parameter int CNT_W      = MIN_LOG2 + NUM_RATES - 1
) (
    input logic               clk,
    input logic               rst,
    blink_rate_timer_if.slave bus
);
    localparam logic [RATE_W-1:0] RATE_MAX = RATE_W'(NUM_RATES - 1);
    localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(RESET_RATE);
    localparam logic [CNT_W-1:0]  CNT_RST  =
        CNT_W'(period_m1(MIN_LOG2, RESET_RATE));

    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] rate_d;
    rate_step_e        step;
    logic [CNT_W-1:0]  reload_val;
    logic [CNT_W-1:0]  cnt_unused;
    logic              zero;

    always_comb begin
        step = RATE_HOLD;
        unique case (1'b1)
            (bus.faster & ~bus.slower): step = RATE_DOWN;
            (bus.slower & ~bus.faster): step = RATE_UP;
            default:                    step = RATE_HOLD;
        endcase
    end

    // Saturate at both ends of the rate range.
    always_comb begin
        rate_d = rate_q;
        unique case (step)
            RATE_DOWN: if (rate_q != '0) rate_d = rate_q - RATE_W'(1);
            RATE_UP:   if (rate_q < RATE_MAX) rate_d = rate_q + RATE_W'(1);
            default:   rate_d = rate_q;
        endcase
    end

    dffr #(.W(RATE_W)) u_rate (
        .clk     (clk),
        .rst     (rst),
        .rst_val (RATE_RST),
        .d       (rate_d),
        .q       (rate_q)
    );

    // Reload uses the pre-edge rate, so a change lands on the next period.
    assign reload_val = CNT_W'(period_m1(MIN_LOG2, int'(rate_q)));

    reload_counter #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (bus.en),
        .reload_val (reload_val),
        .rst_val    (CNT_RST),
        .count      (cnt_unused),
        .zero       (zero)
    );

    assign bus.tick = bus.en & ~rst & zero;
    assign bus.rate = rate_q;
endmodule

// File: tb/tb_blink_rate_timer.sv
// Bench for blink_rate_timer: directed scenarios plus random
// traffic checked against a period/rate reference model.
module tb_blink_rate_timer;
    localparam int MIN_LOG2   = 2;
    localparam int NUM_RATES  = 4;
    localparam int RESET_RATE = 1;
    localparam int RATE_W     = 3;
    localparam int CNT_W      = MIN_LOG2 + NUM_RATES - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    blink_rate_timer_if #(.RATE_W(RATE_W)) bus ();

    blink_rate_timer #(
        .MIN_LOG2   (MIN_LOG2),
        .NUM_RATES  (NUM_RATES),
        .RESET_RATE (RESET_RATE),
        .RATE_W     (RATE_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Blinker stand-in: LED toggles on each tick.
    bit led = 1'b0;
    always @(posedge clk) begin
        if (rst)           led <= 1'b0;
        else if (bus.tick) led <= ~led;
    end

    int total = 0;
    int bad   = 0;

    // Reference model: enabled cycles elapsed in the current period,
    // the length of that period, and the current rate index.
    int m_rate    = RESET_RATE;
    int m_per     = 1 << (MIN_LOG2 + RESET_RATE);
    int m_elapsed = 0;

    logic              obs_tick;
    logic [RATE_W-1:0] obs_rate;
    logic              obs_led;
    logic              exp_tick;
    int                exp_rate;

    function automatic int period(input int k);
        return 1 << (MIN_LOG2 + k);
    endfunction

    task automatic cyc(input logic e, input logic f,
                       input logic s, input logic r);
        bus.en     = e;
        bus.faster = f;
        bus.slower = s;
        rst        = r;
        @(negedge clk);
        obs_tick = bus.tick;
        obs_rate = bus.rate;
        obs_led  = led;
        exp_tick = !r && e && (m_elapsed == m_per - 1);
        exp_rate = m_rate;
        @(posedge clk);
        if (r) begin
            m_rate    = RESET_RATE;
            m_per     = period(RESET_RATE);
            m_elapsed = 0;
        end else begin
            if (e) begin
                if (m_elapsed == m_per - 1) begin
                    m_elapsed = 0;
                    m_per     = period(m_rate);
                end else begin
                    m_elapsed++;
                end
            end
            if (f && !s && m_rate > 0)
                m_rate--;
            else if (s && !f && m_rate < NUM_RATES - 1)
                m_rate++;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1);
            total++;
            if (obs_tick !== 1'b0) begin
                bad++;
                $display("FAIL reset_tick i=%0d got=%b exp=0", i, obs_tick);
            end
            if (i > 0) begin
                total++;
                if (obs_rate !== RATE_W'(RESET_RATE)) begin
                    bad++;
                    $display("FAIL reset_rate got=%0d exp=%0d",
                             obs_rate, RESET_RATE);
                end
            end
        end
    endtask

    task automatic test_periodic();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 26; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            total += 2;
            if (obs_tick !== logic'(i % 8 == 0)) begin
                bad++;
                $display("FAIL periodic_tick cyc=%0d got=%b", i, obs_tick);
            end
            if (obs_rate !== RATE_W'(1)) begin
                bad++;
                $display("FAIL periodic_rate cyc=%0d got=%0d exp=1",
                         i, obs_rate);
            end
        end
    endtask

    task automatic test_faster();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b1, logic'(i == 3), 1'b0, 1'b0);
            total += 2;
            if (obs_tick !== logic'(i == 8 || i == 12 || i == 16)) begin
                bad++;
                $display("FAIL faster_tick cyc=%0d got=%b", i, obs_tick);
            end
            if (obs_rate !== RATE_W'(i >= 4 ? 0 : 1)) begin
                bad++;
                $display("FAIL faster_rate cyc=%0d got=%0d", i, obs_rate);
            end
        end
    endtask

    task automatic test_saturate();
        int er;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 81; i++) begin
            cyc(1'b1, logic'(i >= 41 && i <= 44),
                logic'(i <= 4), 1'b0);
            if (i <= 1)       er = 1;
            else if (i == 2)  er = 2;
            else if (i <= 41) er = 3;
            else if (i == 42) er = 2;
            else if (i == 43) er = 1;
            else              er = 0;
            total += 2;
            if (obs_rate !== RATE_W'(er)) begin
                bad++;
                $display("FAIL sat_rate cyc=%0d got=%0d exp=%0d",
                         i, obs_rate, er);
            end
            if (obs_tick !== logic'(i == 8 || i == 40 || i == 72 ||
                                    i == 76 || i == 80)) begin
                bad++;
                $display("FAIL sat_tick cyc=%0d got=%b", i, obs_tick);
            end
        end
    endtask

    task automatic test_both();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b1, logic'(i == 3), logic'(i == 3), 1'b0);
            total += 2;
            if (obs_tick !== logic'(i == 8 || i == 16)) begin
                bad++;
                $display("FAIL both_tick cyc=%0d got=%b", i, obs_tick);
            end
            if (obs_rate !== RATE_W'(1)) begin
                bad++;
                $display("FAIL both_rate cyc=%0d got=%0d exp=1", i, obs_rate);
            end
        end
    endtask

    task automatic test_enable();
        logic e;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 34; i++) begin
            e = !((i >= 5 && i <= 9) || (i >= 21 && i <= 24));
            cyc(e, 1'b0, 1'b0, 1'b0);
            total++;
            if (obs_tick !== logic'(i == 13 || i == 25 || i == 33)) begin
                bad++;
                $display("FAIL enable_tick cyc=%0d got=%b", i, obs_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++)
            cyc(1'b1, 1'b0, logic'(i <= 2), 1'b0);
        total++;
        if (obs_rate !== RATE_W'(3)) begin
            bad++;
            $display("FAIL mid_pre_rate got=%0d exp=3", obs_rate);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            total += 3;
            if (obs_tick !== logic'(i == 8 || i == 16)) begin
                bad++;
                $display("FAIL mid_tick cyc=%0d got=%b", i, obs_tick);
            end
            if (obs_rate !== RATE_W'(1)) begin
                bad++;
                $display("FAIL mid_rate cyc=%0d got=%0d exp=1", i, obs_rate);
            end
            if (obs_led !== logic'(i > 8 && i <= 16)) begin
                bad++;
                $display("FAIL mid_led cyc=%0d got=%b", i, obs_led);
            end
        end
    endtask

    task automatic test_random();
        logic e, f, s, r;
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 11) == 0);
            s = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 149) == 0);
            cyc(e, f, s, r);
            total += 2;
            if (obs_tick !== exp_tick) begin
                bad++;
                $display("FAIL rand_tick i=%0d got=%b exp=%b",
                         i, obs_tick, exp_tick);
            end
            if (obs_rate !== RATE_W'(exp_rate)) begin
                bad++;
                $display("FAIL rand_rate i=%0d got=%0d exp=%0d",
                         i, obs_rate, exp_rate);
            end
        end
    endtask

    initial begin
        bus.en     = 1'b0;
        bus.faster = 1'b0;
        bus.slower = 1'b0;
        test_reset();
        test_periodic();
        test_faster();
        test_saturate();
        test_both();
        test_enable();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/blink_rate_timer.md
Name: blink_rate_timer

Overview:
- Programmable beat generator sitting directly upstream of the blinker FSM.
- Emits a one-cycle `tick` pulse every P clock cycles; `tick` drives the blinker's `switch` input, so each tick toggles the LED.
- P is a power of two selected by a rate index that the user steps with one-cycle `faster` / `slower` pulses coming from the button conditioner.
- Provides the clock-divider stage so the blinker toggles at a visible rate instead of every cycle.

Parameters:
- MIN_LOG2, default 20: log2 of the shortest period in cycles (rate index 0).
- NUM_RATES, default 6: number of selectable rates; valid range 1..8.
- RESET_RATE, default 3: rate index loaded on reset; must be less than NUM_RATES.
- RATE_W, default 3: width of the rate index.
- CNT_W, default MIN_LOG2+NUM_RATES-1: counter width; holds the longest period minus 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; when low, the counter holds and `tick` is 0.
- faster  in  1  one-cycle pulse; halve the period.
- slower  in  1  one-cycle pulse; double the period.
- tick  out  1  one-cycle beat pulse; connects to blinker `switch`.
- rate  out  RATE_W  current rate index k, for display.

Behaviour:
- Period: P(k) = 2^(MIN_LOG2+k) cycles, with k in 0..NUM_RATES-1.
- State: all state is held in dffr instances. This is a CNT_W-bit down-counter `count` plus the RATE_W-bit `rate` register. There is no other FSM.
- Reset (rst=1 at a clock edge):
  - `rate` = RESET_RATE.
  - `count` = P(RESET_RATE)-1.
  - While rst=1, `tick` is forced to 0.
  - rst has priority over en, faster and slower.
  - A reset mid-period discards the partial count.
- `tick` is combinational: tick = en & ~rst & (count == 0). It is high for exactly one cycle per period when en stays high.
- Counter update per edge (rst=0):
  - en=0: `count` holds.
  - en=1 and count != 0: `count` = count-1.
  - en=1 and count == 0: `count` = P(rate)-1, using the `rate` register value before the edge.
- Timing: with en held high from reset release, the first tick is in cycle P (cycle 1 is the first cycle after rst falls). Later ticks occur every P cycles.
- Rate update per edge (rst=0), independent of en:
  - faster=1, slower=0: if rate > 0 then rate-1, else hold (saturate at 0).
  - slower=1, faster=0: if rate < NUM_RATES-1 then rate+1, else hold (saturate).
  - Both asserted, or neither: hold.
- Rate change timing:
  - A rate change does not disturb the in-flight count. The new period applies from the next reload.
  - If a rate change and a reload happen on the same edge, the reload uses the old rate.
- Width rule: P(k)-1 is computed as a left-shift of 1 by (MIN_LOG2+k), minus 1, at CNT_W bits. No truncation occurs for any legal k.
- Input assumptions: inputs are synchronous to clk. Pulses longer than one cycle step the rate once per cycle; the upstream conditioner guarantees single-cycle pulses.

Decomposition:
- Shared package/header holds:
  - the rate-step constants `RATE_HOLD`, `RATE_UP`, `RATE_DOWN`;
  - the period-minus-one function/macro used by both the reset value and the reload path.
- Natural sub-module: `reload_counter`, a parameterised loadable down-counter built on dffr.
  - Inputs: clk, rst, en, reload value, reset value.
  - Outputs: count, zero flag.
- `blink_rate_timer` instantiates `reload_counter` and owns the rate register and saturation logic.

Test Plan:
All scenarios use MIN_LOG2=2, NUM_RATES=4, RESET_RATE=1, giving P=8, with en=1 unless stated.
1. Reset release, no buttons -> `tick` high in cycles 8, 16, 24 only; `rate`=1 throughout; `tick`=0 during rst.
2. `faster` pulse in cycle 3 -> `rate`=0 from cycle 4. Tick still at cycle 8 (old period), then at 12 and 16 (P=4).
3. Four `slower` pulses -> `rate` goes 2, 3, 3, 3 (saturates). Period becomes 32 after the next reload. Four `faster` pulses from rate 3 -> `rate` goes 2, 1, 0, 0.
4. `faster` and `slower` both high in one cycle -> `rate` unchanged, tick spacing unchanged.
5. en=0 for cycles 5-9 -> counter frozen, no tick. The first tick arrives in cycle 13; with en held low while count==0, `tick` stays 0 and no reload occurs.
6. rst pulsed in cycle 5 of a period with `rate`=3 -> after release, `rate`=1 and the first tick is at cycle 8 after release. Chain into the blinker: LED toggles on every tick.
